// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the uart_rx command sequencer: opcode bytes,
// operand register addresses and the sequencer state encoding.
package uart_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_OPA,
        ALU_OPB,
        ALU_FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } ctrl_state_e;

    // States that are waiting for the next byte of a partially received frame.
    function automatic logic is_mid_frame(input ctrl_state_e s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
               (s == ALU_OPA) || (s == ALU_OPB) || (s == ALU_FUN);
    endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_timeout.sv
// Inter-byte timeout counter for the command sequencer.
// Only built when CMD_TIMEOUT_EN is defined; the default build has no counter.
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expired = run && (count == LAST);

    // Restart on every byte or whenever no frame is in progress; otherwise count up to the limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer downstream of uart_rx: parses framed byte commands into
// register-file writes/reads and ALU operations, and returns read data / ALU
// results as bytes on a valid/ready handshake toward the TX path.
// Optional inter-byte timeout: define CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic                rf_wr_en,
    output logic [DATA_W-1:0]   rf_wr_data,
    output logic                rf_rd_en,
    input  logic [DATA_W-1:0]   rf_rd_data,
    input  logic                rf_rd_valid,
    output logic                alu_en,
    output logic [3:0]          alu_fun,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic                alu_out_valid,
    output logic [DATA_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                cmd_err
);

    ctrl_state_e state_q, state_d;

    logic [ADDR_W-1:0] rf_addr_d;
    logic              rf_wr_en_d;
    logic [DATA_W-1:0] rf_wr_data_d;
    logic              rf_rd_en_d;
    logic              alu_en_d;
    logic [3:0]        alu_fun_d;
    logic [DATA_W-1:0] tx_data_d;
    logic              tx_valid_d;
    logic              cmd_err_d;
    logic [DATA_W-1:0] hi_byte_q, hi_byte_d;
    logic              timeout_hit;

`ifdef CMD_TIMEOUT_EN
    logic in_frame;

    assign in_frame = is_mid_frame(state_q);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rx_valid),
        .run     (in_frame),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output decode; every output is then registered below.
    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr;
        rf_wr_en_d   = 1'b0;
        rf_wr_data_d = rf_wr_data;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun;
        tx_data_d    = tx_data;
        tx_valid_d   = tx_valid;
        cmd_err_d    = 1'b0;
        hi_byte_d    = hi_byte_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == DATA_W'(CMD_WR))           state_d = WR_ADDR;
                    else if (rx_data == DATA_W'(CMD_RD))      state_d = RD_ADDR;
                    else if (rx_data == DATA_W'(CMD_ALU_OP))  state_d = ALU_OPA;
                    else if (rx_data == DATA_W'(CMD_ALU_NOP)) state_d = ALU_FUN;
                    else                                      cmd_err_d = 1'b1;
                end
            end
            WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_W-1:0];
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = rx_data;
                    state_d      = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cmd_err_d = rx_valid;
                if (rf_rd_valid) begin
                    tx_data_d  = rf_rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = TX_HI;
                end
            end
            ALU_OPA: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(OPA_ADDR);
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = rx_data;
                    state_d      = ALU_OPB;
                end
            end
            ALU_OPB: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(OPB_ADDR);
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = rx_data;
                    state_d      = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (rx_valid) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = rx_data[3:0];
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                cmd_err_d = rx_valid;
                if (alu_out_valid) begin
                    tx_data_d  = alu_out[DATA_W-1:0];
                    hi_byte_d  = alu_out[2*DATA_W-1:DATA_W];
                    tx_valid_d = 1'b1;
                    state_d    = TX_LO;
                end
            end
            TX_LO: begin
                cmd_err_d = rx_valid;
                if (tx_ready) begin
                    tx_data_d = hi_byte_q;
                    state_d   = TX_HI;
                end
            end
            TX_HI: begin
                cmd_err_d = rx_valid;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit && !rx_valid) begin
            state_d   = IDLE;
            cmd_err_d = 1'b1;
        end
    end

    // State and output registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rf_addr    <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_data <= '0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
            hi_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            rf_addr    <= rf_addr_d;
            rf_wr_en   <= rf_wr_en_d;
            rf_wr_data <= rf_wr_data_d;
            rf_rd_en   <= rf_rd_en_d;
            alu_en     <= alu_en_d;
            alu_fun    <= alu_fun_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            cmd_err    <= cmd_err_d;
            hi_byte_q  <= hi_byte_d;
        end
    end

endmodule
